// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry, scanner state encoding and column-priority helper.
package keypad_pkg;
   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 3;
   localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'b1111;
   typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, DONE} state_t;
   // Lowest-index active-low column wins; caller guarantees at least one bit is 0.
   function automatic logic [1:0] lowest_zero(input logic [NUM_COLS-1:0] c);
      return !c[0] ? 2'd0 : !c[1] ? 2'd1 : 2'd2;
   endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: W-bit two-flop synchronizer, async reset to all-ones (idle level of active-low lines).
module keypad_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clk or posedge reset)
      if (reset) {q, meta} <= '1;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 active-low matrix keypad scanner reporting the first pressed key.
// Define KEYPAD_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable samples before committing.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES   = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [NUM_COLS-1:0] cols,
   output logic [NUM_ROWS-1:0] rows,
   output logic [31:0]         foundRow,
   output logic [31:0]         foundCol,
   output logic                dataReady
);
   // One counter serves both settle dwell and debounce run length.
   localparam int CW = $clog2((SETTLE_CYCLES > DEBOUNCE_CYCLES ? SETTLE_CYCLES : DEBOUNCE_CYCLES) + 1);
   state_t state, state_n;
   logic [1:0] row, row_n, frow, fcol;
   logic [CW-1:0] cnt, cnt_n;
   logic [NUM_COLS-1:0] scols, hit_cols;
   logic [NUM_ROWS-1:0] rows_n;
   logic sample, commit;
`ifdef KEYPAD_DEBOUNCE_EN
   logic [NUM_COLS-1:0] pat, pat_n;
   assign hit_cols = pat;
`else
   assign hit_cols = scols;
`endif

   keypad_sync #(.W(NUM_COLS)) u_sync (.clk(clk), .reset(reset), .d(cols), .q(scols));

   assign sample   = state == SCAN && cnt == CW'(SETTLE_CYCLES - 1);
   assign foundRow = {30'd0, frow};
   assign foundCol = {30'd0, fcol};

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         row   <= '0;
         cnt   <= '0;
         rows  <= ROWS_IDLE;
         frow  <= '0;
         fcol  <= '0;
`ifdef KEYPAD_DEBOUNCE_EN
         pat   <= '1;
`endif
      end else begin
         state <= state_n;
         row   <= row_n;
         cnt   <= cnt_n;
         rows  <= rows_n;
`ifdef KEYPAD_DEBOUNCE_EN
         pat   <= pat_n;
`endif
         if (commit) begin
            frow <= row;
            fcol <= lowest_zero(hit_cols);
         end
      end

   always_comb begin
      state_n = state;
      row_n   = row;
      cnt_n   = cnt + CW'(1);
      commit  = 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
      pat_n   = pat;
`endif
      if (!start) state_n = IDLE;
      else
         case (state)
            IDLE: begin
               state_n = SCAN;
               row_n   = '0;
               cnt_n   = '0;
            end
            SCAN:
               if (sample) begin
                  cnt_n = '0;
                  if (scols == '1) row_n = row + 2'd1;
`ifdef KEYPAD_DEBOUNCE_EN
                  else begin
                     state_n = DEBOUNCE;
                     pat_n   = scols;
                  end
`else
                  else begin
                     state_n = DONE;
                     commit  = 1'b1;
                  end
`endif
               end
`ifdef KEYPAD_DEBOUNCE_EN
            DEBOUNCE:
               if (scols != pat) begin
                  state_n = SCAN;
                  row_n   = row + 2'd1;
                  cnt_n   = '0;
               end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                  state_n = DONE;
                  commit  = 1'b1;
               end
`endif
            default: ;
         endcase
   end

   always_comb begin
      rows_n    = (state_n == SCAN || state_n == DEBOUNCE) ? ~(NUM_ROWS'(1) << row_n) : ROWS_IDLE;
      dataReady = state == DONE;
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized key matrices checked against a timing model of the scan order.
module tb_keypad_scanner;
   localparam int S = 4;
`ifdef KEYPAD_DEBOUNCE_EN
   localparam int DEB = 16;
`else
   localparam int DEB = 0;
`endif
   logic clk = 0, reset = 0, start = 0;
   logic [2:0] cols;
   logic [3:0] rows;
   logic [31:0] found_row, found_col;
   logic data_ready;
   logic [11:0] keys = '0;
   logic ovr_en = 0, glitch = 0;
   logic [2:0] ovr = 3'b111;
   int checks = 0, failures = 0;
   int exp_row = 0, exp_col = 0;

   keypad_scanner dut (
      .clk(clk), .reset(reset), .start(start), .cols(cols), .rows(rows),
      .foundRow(found_row), .foundCol(found_col), .dataReady(data_ready)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key shorts its column low while its row is driven low.
   always_comb begin
      cols = 3'b111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (!rows[r] && keys[r*3+c]) cols[c] = 1'b0;
      if (glitch) cols[0] = 1'b0;
      if (ovr_en) cols = ovr;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_rows"}, 32'(rows), 32'hf);
      check({tag, "_ready"}, 32'(data_ready), 0);
      check({tag, "_frow"}, found_row, exp_row);
      check({tag, "_fcol"}, found_col, exp_col);
   endtask

   // Hold start for n cycles with the given key matrix, checking the row walk each cycle.
   task automatic trial(input logic [11:0] k_in, input int n);
      int rd, cd, tdet, tdone;
      logic [3:0] er;
      keys = k_in;
      rd = -1;
      cd = 0;
      for (int r = 3; r >= 0; r--) if (k_in[r*3+:3] != 3'b000) rd = r;
      if (rd >= 0) for (int c = 2; c >= 0; c--) if (k_in[rd*3+c]) cd = c;
      tdet  = rd < 0 ? 1 << 30 : S * (rd + 1);
      tdone = tdet + DEB;
      @(negedge clk);
      start = 1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         er = k >= tdone ? 4'b1111 : k >= tdet ? ~(4'b1 << rd) : ~(4'b1 << ((k / S) % 4));
         check("rows", 32'(rows), 32'(er));
         check("ready", 32'(data_ready), 32'(k >= tdone));
      end
      start = 0;
      if (n - 1 >= tdone) begin
         exp_row = rd;
         exp_col = cd;
      end
      @(negedge clk);
      check_idle("after");
      @(negedge clk);
   endtask

   initial begin
      start = 1;
      ovr_en = 1;
      ovr = 3'b000;
      #1 reset = 1;
      #1 check_idle("rst_now");
      repeat (3) @(negedge clk);
      check_idle("rst_hold");
      start = 0;
      reset = 0;
      ovr_en = 0;
      @(negedge clk);

      trial(12'h004, 40);
      trial(12'h000, 40);
      trial(12'h003, 40);
      trial(12'h408, 40);
      trial(12'h080, 40);

      @(negedge clk);
      keys = 12'h000;
      start = 1;
      repeat (6) @(negedge clk);
      #2 reset = 1;
      exp_row = 0;
      exp_col = 0;
      #1 check_idle("rst_mid");
      @(negedge clk);
      start = 0;
      reset = 0;
      @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         logic [11:0] kk;
         kk = $urandom_range(0, 3) == 0 ? 12'h000 : 12'(1 << $urandom_range(0, 11));
         if ($urandom_range(0, 1) == 1) kk = kk | 12'(1 << $urandom_range(0, 11));
         trial(kk, int'($urandom_range(1, 45)));
      end

`ifdef KEYPAD_DEBOUNCE_EN
      keys = 12'h000;
      @(negedge clk);
      start = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         glitch = k == 5;
         if (k == 10) check("glitch_rows", 32'(rows), 32'hb);
         if (k == 19) check("glitch_ready", 32'(data_ready), 0);
      end
      glitch = 0;
      start = 0;
      @(negedge clk);
      check_idle("glitch_after");
      trial(12'h008, 40);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Matrix-keypad scanner for a 4-row x 3-column keypad (ATM PIN/amount entry).
- Drives rows active-low one at a time and samples the active-low column lines.
- Reports the row/column index of the first pressed key to the processor via 32-bit index outputs and a dataReady level.
- Sits between the board keypad pins and the processor I/O registers.

Parameters:
SETTLE_CYCLES, 4, clock cycles each row is driven before columns are sampled; minimum 3, which covers the 2-flop synchronizer.
DEBOUNCE_CYCLES, 16, consecutive stable samples required when KEYPAD_DEBOUNCE_EN is defined.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  level request to scan; must stay high until the result is consumed.
cols  input  3  keypad column lines, active-low (0 = key in driven row pressed), asynchronous to clk.
rows  output  4  keypad row drive, active-low, registered; exactly one bit low while scanning, else 4'b1111.
foundRow  output  32  index 0..3 of the detected key's row, zero-extended.
foundCol  output  32  index 0..2 of the detected key's column, zero-extended.
dataReady  output  1  high while foundRow/foundCol hold a valid result for the current start.

Behaviour:
- Reset state:
  - rows=4'b1111, dataReady=0, foundRow=0, foundCol=0.
  - State IDLE, row index 0, dwell counter 0, synchronizer flops 3'b111.
- cols is passed through a 2-flop synchronizer; all sampling uses the synchronized value.
- State IDLE:
  - rows=1111, dataReady=0.
  - If start=1 at an edge: go to SCAN with row index 0, rows=~(1<<0), counter 0.
- State SCAN:
  - rows=~(1<<r). Counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES-1, sample the synchronized cols.
  - Any bit 0: foundRow=r, foundCol=lowest-index 0 bit (col0 has priority), dataReady=1, rows=1111, go to DONE.
  - All 1: r advances (3 wraps to 0), counter resets, scanning continues indefinitely while start=1.
- State DONE:
  - rows=1111, dataReady=1, results frozen; column changes are ignored.
  - When start=0 at an edge: dataReady=0, go to IDLE.
- start=0 at any edge during SCAN: abort to IDLE (rows=1111, dataReady=0); foundRow/foundCol retain their previous values.
- foundRow/foundCol change only on a successful detection or reset.
- Latency without debounce:
  - Start sampled at edge E0, key held in row r: dataReady rises at edge E0+SETTLE_CYCLES*(r+1).
  - Default parameters, row 0: 4 cycles.
- Multiple keys in different rows: the lowest row reached first in scan order wins.
- reset asserted mid-scan or in DONE: immediate return to reset values regardless of clk.

Optional Feature:
Macro KEYPAD_DEBOUNCE_EN.
- Defined:
  - After a detection sample, the scanner stays on the same row in a DEBOUNCE state.
  - It compares the synchronized cols each cycle to the captured pattern.
  - DEBOUNCE_CYCLES consecutive matches: commit result and go to DONE.
  - Any mismatch: abandon and resume SCAN at the next row.
  - Latency increases by DEBOUNCE_CYCLES.
- Not defined: the first low sample is accepted; no DEBOUNCE state or counter logic is synthesized.

Decomposition:
- Package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=3.
  - State enum: IDLE, SCAN, DEBOUNCE, DONE.
  - Row-drive idle constant 4'b1111.
- One sub-module keypad_sync: parameterized-width 2-flop synchronizer with async reset to all-ones, instantiated for cols.

Test Plan:
- Reset asserted with start=1, cols=3'b000 -> rows=1111, dataReady=0, foundRow=0, foundCol=0 immediately.
- start=1, cols=3'b011 held, default params -> scanning begins at row 0; dataReady=1 4 cycles after start sampled; foundRow=0, foundCol=2; rows=1111; then start=0 -> dataReady=0 next edge, results retained.
- Bench models key (row 2, col 1) by driving cols[1]=0 only when rows[2]=0 -> rows walks 1110,1101,1011 at 4 cycles each; dataReady at cycle 12; foundRow=2, foundCol=1.
- start=1 with cols=3'b111 for 40 cycles -> rows cycles 1110,1101,1011,0111 and wraps repeatedly; dataReady stays 0; start=0 -> rows=1111.
- cols=3'b100 (cols 0 and 1 low) while row 0 driven -> foundCol=0 (lowest index priority).
- With KEYPAD_DEBOUNCE_EN: 1-cycle glitch on cols[0] during row 1 sample -> no detection, scan continues. Held low 20 cycles -> dataReady after DEBOUNCE_CYCLES matches, foundRow=1, foundCol=0.
